// File: rtl/serializer_piso_if.sv
// serializer_piso_if
// -----------------------------------------------------------------------------
// Groups the word-side handshake and the serial-side outputs of the
// parallel-in / serial-out serializer into one bundle.
//
// Handshake semantics (word side, strict valid/ready):
//   A word transfers on a rising clk edge where in_valid=1 and in_ready=1.
//   in_ready is driven from state registers only and never depends on
//   in_valid in the same cycle. in_valid asserted while in_ready=0 is
//   ignored. The producer may hold or change in_data freely while waiting.
//
// Signals:
//   in_data      [WIDTH-1:0]  parallel word to serialize   (master -> slave)
//   in_valid                  in_data is valid this cycle  (master -> slave)
//   in_ready                  slave can take a word        (slave  -> master)
//   serial_out                serial data bit, MSB first   (slave  -> master)
//   serial_valid              serial_out carries a bit     (slave  -> master)
//   frame_done                pulse with the last frame bit(slave  -> master)
//
// Modports:
//   master : the side that supplies words and observes the serial stream
//   slave  : the serializer itself
// -----------------------------------------------------------------------------
interface serializer_piso_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_done;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  serial_out,
    input  serial_valid,
    input  frame_done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output serial_out,
    output serial_valid,
    output frame_done
  );

endinterface : serializer_piso_if

// File: rtl/serializer_piso.sv
// serializer_piso
// -----------------------------------------------------------------------------
// Parallel-in / serial-out serializer. A WIDTH-bit word accepted over a
// valid/ready handshake is shifted out MSB first, one bit per clock, into a
// downstream shift-left SIPO stage. The word is held in an internal shift
// register, so in_data may change freely once it has been captured.
//
// Optional feature (compile-time macro SERIALIZER_PARITY_EN):
//   When defined, one even-parity bit (XOR of all WIDTH data bits) follows
//   bit 0 with serial_valid=1, and frame_done moves to that parity bit.
//   When undefined, the PARITY state and the parity register do not exist
//   and every frame is exactly WIDTH bits.
//
// Timing (no parity, WIDTH=4):
//   edge 0      : word captured, IDLE -> SHIFT
//   cycles 1..4 : serial_out = d[3], d[2], d[1], d[0]; frame_done on cycle 4
//   cycle 5     : back in IDLE, in_ready=1, next capture possible
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous, active-low reset (0 = reset asserted)
//   bus          if   serializer_piso_if.slave (handshake + serial stream)
//   dbg_state_o  out  current FSM state encoding, for checkers/debug
// -----------------------------------------------------------------------------
module serializer_piso #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  serializer_piso_if.slave        bus,
  output logic [1:0]              dbg_state_o
);

  // Down-counter of remaining bits after the one currently presented.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
  } state_e;
`endif

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
`ifdef SERIALIZER_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // Outputs are decoded from registered state only, so they drop to zero
  // the instant reset clears the registers, and in_ready has no path from
  // in_valid.
  logic               serial_out_c;
  logic               serial_valid_c;
  logic               frame_done_c;
  logic               in_ready_c;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shreg_d        = shreg_q;
`ifdef SERIALIZER_PARITY_EN
    parity_d       = parity_q;
`endif
    serial_out_c   = 1'b0;
    serial_valid_c = 1'b0;
    frame_done_c   = 1'b0;
    in_ready_c     = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        // in_ready is 1 in IDLE, so in_valid alone completes the transfer.
        if (bus.in_valid) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(WIDTH - 1);
          shreg_d = bus.in_data;
`ifdef SERIALIZER_PARITY_EN
          // Even parity of the captured word; computed once at capture so
          // later in_data changes cannot leak into the frame.
          parity_d = ^bus.in_data;
`endif
        end
      end

      SHIFT: begin
        serial_out_c   = shreg_q[WIDTH-1];
        serial_valid_c = 1'b1;
        // Shift left so the next lower bit becomes the presented MSB; zeros
        // fill in, leaving the register cleared when the frame ends.
        shreg_d        = {shreg_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
`ifdef SERIALIZER_PARITY_EN
          state_d      = PARITY;
`else
          state_d      = IDLE;
          frame_done_c = 1'b1;
`endif
        end else begin
          // Guarded decrement: the counter never wraps below zero.
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        serial_out_c   = parity_q;
        serial_valid_c = 1'b1;
        frame_done_c   = 1'b1;
        state_d        = IDLE;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output connections
  // ---------------------------------------------------------------------------
  assign bus.in_ready     = in_ready_c;
  assign bus.serial_out   = serial_out_c;
  assign bus.serial_valid = serial_valid_c;
  assign bus.frame_done   = frame_done_c;
  assign dbg_state_o      = state_q;

endmodule : serializer_piso

// File: tb/tb_serializer_piso.sv
// tb_serializer_piso
// -----------------------------------------------------------------------------
// Directed + random bench for serializer_piso (WIDTH=4). A small timing model
// (busy counter) predicts in_ready/serial_valid; every accepted word pushes its
// expected bit stream into exp_q, which is popped as serial bits appear.
// A 4-bit shift-left SIPO model rebuilds each word from the serial stream.
// Build with +define+SERIALIZER_PARITY_EN to exercise the parity frame.
// -----------------------------------------------------------------------------
module tb_serializer_piso;

  localparam int W = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam int NB  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = W;
  localparam bit PAR = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serializer_piso_if #(.WIDTH(W)) bus ();
  logic [1:0] dbg_state;

  serializer_piso #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  // Entry: {is_data_bit, expected_frame_done, expected_bit}
  logic [2:0]   exp_q[$];
  logic [W-1:0] word_q[$];
  int           passed = 0;
  int           failed = 0;
  int           total  = 0;
  int           busy   = 0;
  bit           last_cap;
  logic [W-1:0] sipo_q;
  int           sipo_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      exp_q.push_back({1'b1, (i == 0) && !PAR, w[i]});
    end
    if (PAR) exp_q.push_back({1'b0, 1'b1, ^w});
    word_q.push_back(w);
  endtask

  task automatic check_outputs();
    logic [2:0] e;
    check("serial_valid", {31'b0, bus.serial_valid}, {31'b0, busy > 0});
    if (busy > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("serial_out", {31'b0, bus.serial_out}, {31'b0, e[0]});
      check("frame_done", {31'b0, bus.frame_done}, {31'b0, e[1]});
      if (e[2]) begin
        sipo_q = {sipo_q[W-2:0], bus.serial_out};
        sipo_n++;
        if (sipo_n == W) begin
          sipo_n = 0;
          check("sipo_word", {28'b0, sipo_q}, {28'b0, word_q.pop_front()});
        end
      end
    end else begin
      check("serial_out_idle", {31'b0, bus.serial_out}, 32'd0);
      check("frame_done_idle", {31'b0, bus.frame_done}, 32'd0);
      if (reset === 1'b1) check("dbg_state_idle", {30'b0, dbg_state}, 32'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One clock: predict capture from the model, advance, then check outputs.
  task automatic cycle();
    bit           cap;
    logic [W-1:0] w;
    cap = (bus.in_valid === 1'b1) && (busy == 0) && (reset === 1'b1);
    w   = bus.in_data;
    if (reset === 1'b1) check("in_ready", {31'b0, bus.in_ready}, {31'b0, busy == 0});
    @(posedge clk);
    #1;
    last_cap = cap;
    if (reset !== 1'b1)  busy = 0;
    else if (cap) begin
      busy = NB;
      push_word(w);
    end else if (busy > 0) busy--;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [W-1:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    cycle();
    check("accepted", {31'b0, last_cap}, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int tries;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    sipo_q       = '0;
    sipo_n       = 0;
    last_cap     = 1'b0;

    // Reset state
    #2;
    check("rst_serial_valid", {31'b0, bus.serial_valid}, 32'd0);
    check("rst_serial_out",   {31'b0, bus.serial_out},   32'd0);
    check("rst_frame_done",   {31'b0, bus.frame_done},   32'd0);
    check("rst_state",        {30'b0, dbg_state},        32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // First capture on the first edge with reset released, then 1011
    send(4'b1011);
    idle(NB + 1);

    // 0110: parity bit 0 when parity is built in
    send(4'b0110);
    idle(NB + 1);

    // in_valid held high: 1111 then 0001 must wait for the IDLE cycle
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1111;
    cycle();
    check("held_first_cap", {31'b0, last_cap}, 32'd1);
    bus.in_data = 4'b0001;
    tries = 0;
    do begin
      cycle();
      tries++;
    end while (!last_cap && tries < 20);
    check("held_second_cap", {31'b0, last_cap}, 32'd1);
    check("held_wait_cycles", tries, NB + 1);
    bus.in_valid = 1'b0;
    idle(NB + 1);

    // in_data toggling during a frame must not disturb it
    send(4'b1001);
    repeat (NB + 1) begin
      bus.in_data = W'($urandom_range(0, (1 << W) - 1));
      cycle();
    end

    // Reset after the 2nd bit of 1100, then a clean 0101 frame
    send(4'b1100);
    cycle();
    reset = 1'b0;
    #1;
    check("abort_serial_valid", {31'b0, bus.serial_valid}, 32'd0);
    check("abort_serial_out",   {31'b0, bus.serial_out},   32'd0);
    check("abort_frame_done",   {31'b0, bus.frame_done},   32'd0);
    check("abort_state",        {30'b0, dbg_state},        32'd0);
    exp_q.delete();
    word_q.delete();
    sipo_n = 0;
    busy   = 0;
    idle(2);
    reset = 1'b1;
    #1;
    check("rel2_in_ready", {31'b0, bus.in_ready}, 32'd1);
    send(4'b0101);
    idle(NB + 1);

    // Random words with random gaps and a held in_valid
    for (int k = 0; k < 50; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom_range(0, (1 << W) - 1));
      tries = 0;
      do begin
        cycle();
        tries++;
      end while (!last_cap && tries < 20);
      if (!last_cap) check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      idle($urandom_range(0, 2));
    end
    idle(NB + 2);

    check("exp_q_drained",  exp_q.size(),  32'd0);
    check("word_q_drained", word_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_serializer_piso
